sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 172 +++++++++++++++++
 tb/tb_sram_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
//
// Bridges a 32-bit CPU MEM-stage load/store port onto an asynchronous 16-bit
// SRAM. Each 32-bit access is split into two halfword phases (LOW then HIGH).
// Each phase lasts WAIT_STATES+1 cycles. The pipeline is frozen via `ready`
// until the access finishes.
//
// Parameters
//   ADDR_OFFSET : CPU byte address that maps to SRAM word 0.
//   WAIT_STATES : extra SRAM cycles per halfword phase (0..7).
//
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset
//   wr_en      : store request, held by the CPU until ready
//   rd_en      : load request, held by the CPU until ready (write wins if both)
//   address    : CPU byte address
//   write_data : store data
//   read_data  : registered load result, held until the next load completes
//   ready      : low freezes the pipeline; high when idle or in DONE
//   SRAM_DQ    : bidirectional 16-bit SRAM data bus
//   SRAM_ADDR  : SRAM halfword address ({word_index, half_select})
//   SRAM_WE_N  : active-low write strobe
//   SRAM_OE_N  : active-low output enable
// -----------------------------------------------------------------------------
module sram_controller #(
    parameter int unsigned ADDR_OFFSET = 1024,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N
);

    localparam logic [2:0] LP_LAST = 3'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_next;
    logic        r_is_write;
    logic [16:0] r_waddr;
    logic [31:0] r_wdata;
    logic [15:0] r_rd_low;
    logic [31:0] r_rdata;

    logic        w_req;
    logic [16:0] w_waddr_in;
    logic        w_phase_last;
    logic        w_we_window;
    logic        w_dq_oe;
    logic [15:0] w_dq_out;

    assign w_req = wr_en | rd_en;

    // Word index relative to the data-memory base. The subtraction wraps
    // modulo 2^32 and only the low 17 bits of the word index are kept, so
    // out-of-range addresses alias silently into the SRAM.
    assign w_waddr_in = 17'((address - 32'(ADDR_OFFSET)) >> 2);

    assign w_phase_last = (r_cnt == LP_LAST);

    // WE_N is low for the first WAIT_STATES cycles of a phase. The final
    // cycle keeps the data driven with WE_N high, giving hold time after
    // the strobe rises. With zero wait states the phase is a single cycle,
    // and the strobe must still pulse in that cycle.
    assign w_we_window = (LP_LAST == 3'd0) || (r_cnt < LP_LAST);

    assign SRAM_DQ   = w_dq_oe ? w_dq_out : 16'hzzzz;
    assign read_data = r_rdata;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        ready        = 1'b0;
        SRAM_ADDR    = 18'h0;
        SRAM_WE_N    = 1'b1;
        SRAM_OE_N    = 1'b1;
        w_dq_oe      = 1'b0;
        w_dq_out     = 16'h0;

        case (r_state)
            ST_IDLE: begin
                // Drop ready as soon as a request is seen, so the CPU stays
                // frozen in the same cycle it issues the access.
                ready = ~w_req;
                if (w_req) begin
                    w_state_next = ST_LOW;
                    w_cnt_next   = 3'd0;
                end
            end

            ST_LOW, ST_HIGH: begin
                SRAM_ADDR = {r_waddr, (r_state == ST_HIGH)};
                w_dq_out  = (r_state == ST_HIGH) ? r_wdata[31:16] : r_wdata[15:0];
                if (r_is_write) begin
                    w_dq_oe   = 1'b1;
                    SRAM_WE_N = ~w_we_window;
                end else begin
                    SRAM_OE_N = 1'b0;
                end
                if (w_phase_last) begin
                    w_state_next = (r_state == ST_LOW) ? ST_HIGH : ST_DONE;
                    w_cnt_next   = 3'd0;
                end else begin
                    w_cnt_next   = r_cnt + 3'd1;
                end
            end

            ST_DONE: begin
                ready        = 1'b1;
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 3'd0;
            r_is_write <= 1'b0;
            r_waddr    <= 17'h0;
            r_wdata    <= 32'h0;
            r_rd_low   <= 16'h0;
            r_rdata    <= 32'h0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;

            // Capture the transaction on IDLE exit. The CPU may change its
            // inputs (or drop the request) afterwards without effect.
            if ((r_state == ST_IDLE) && w_req) begin
                r_is_write <= wr_en;
                r_waddr    <= w_waddr_in;
                r_wdata    <= write_data;
            end

            // The low half is staged separately, so read_data only changes
            // once the whole word is available. The old value stays visible
            // until then.
            if (!r_is_write && w_phase_last) begin
                if (r_state == ST_LOW) begin
                    r_rd_low <= SRAM_DQ;
                end else if (r_state == ST_HIGH) begin
                    r_rdata <= {SRAM_DQ, r_rd_low};
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;

    localparam int unsigned W   = 2;
    localparam int unsigned OFF = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data, read_data;
    logic        ready;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N, SRAM_OE_N;

    // Second instance with zero wait states, read-only directed check.
    logic        rd_en0;
    logic [31:0] address0, read_data0;
    logic        ready0;
    wire  [15:0] SRAM_DQ0;
    logic [17:0] SRAM_ADDR0;
    logic        SRAM_WE_N0, SRAM_OE_N0;

    sram_controller #(.ADDR_OFFSET(OFF), .WAIT_STATES(W)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N)
    );

    sram_controller #(.ADDR_OFFSET(OFF), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .wr_en(1'b0), .rd_en(rd_en0),
        .address(address0), .write_data(32'h0), .read_data(read_data0),
        .ready(ready0), .SRAM_DQ(SRAM_DQ0), .SRAM_ADDR(SRAM_ADDR0),
        .SRAM_WE_N(SRAM_WE_N0), .SRAM_OE_N(SRAM_OE_N0)
    );

    // Behavioural SRAM chips
    logic [15:0] sram [0:262143];
    assign SRAM_DQ  = (!SRAM_OE_N)  ? sram[SRAM_ADDR] : 16'hzzzz;
    assign SRAM_DQ0 = (!SRAM_OE_N0) ? {4'hA, SRAM_ADDR0[11:0]} : 16'hzzzz;

    initial begin
        for (int i = 0; i < 262144; i++) sram[i] = 16'h0;
        forever begin
            @(posedge clk);
            if (!SRAM_WE_N) sram[SRAM_ADDR] = SRAM_DQ;
        end
    end

    // Reference model: 32-bit word memory plus last completed load
    logic [31:0] model_word [0:131071];
    logic [31:0] model_last_rd;

    typedef struct {
        bit          is_wr;
        logic [16:0] waddr;
        logic [31:0] data;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] waddr_of(input logic [31:0] a);
        logic [31:0] d;
        d = a - 32'(OFF);
        return 17'(d / 4);
    endfunction

    // Issue one transaction; optionally disturb inputs mid-flight
    task automatic do_txn(input bit wr, input bit rd, input logic [31:0] addr,
                          input logic [31:0] data, input bit disturb);
        exp_t e;
        int   n;
        bit   done;
        e.is_wr = wr;
        e.waddr = waddr_of(addr);
        if (wr) begin
            model_word[e.waddr] = data;
            e.data  = data;
            e.rdata = model_last_rd;
        end else begin
            e.data        = model_word[e.waddr];
            model_last_rd = model_word[e.waddr];
            e.rdata       = model_last_rd;
        end
        sb_q.push_back(e);
        $display("txn %s addr=0x%08h data=0x%08h waddr=0x%05h disturb=%0d",
                 wr ? (rd ? "WR+RD" : "WR") : "RD", addr, e.data, e.waddr, disturb);
        @(posedge clk); #1;
        wr_en = wr; rd_en = rd; address = addr; write_data = data;
        n = 0; done = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
            if (disturb && n == 3) begin
                address    = $urandom;
                write_data = $urandom;
                if ($urandom_range(1) == 1) begin
                    wr_en = 0; rd_en = 0;
                end
            end
            if (ready) done = 1;
        end
        check("txn_cycles", 32'(n), 32'(2 * W + 4));
        @(posedge clk); #1;
        wr_en = 0; rd_en = 0;
    endtask

    // Monitor / scoreboard
    bit          mon_in_txn = 0;
    int          mon_lo, mon_oe, mon_we;
    bit          mon_have_addr;
    logic [17:0] mon_first, mon_last;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mon_in_txn = 0;
            end else if (!ready) begin
                if (!mon_in_txn) begin
                    mon_in_txn = 1; mon_lo = 0; mon_oe = 0; mon_we = 0; mon_have_addr = 0;
                end
                mon_lo++;
                if (!SRAM_OE_N) mon_oe++;
                if (!SRAM_WE_N) mon_we++;
                if (!SRAM_OE_N || !SRAM_WE_N) begin
                    if (!mon_have_addr) mon_first = SRAM_ADDR;
                    mon_have_addr = 1;
                    mon_last = SRAM_ADDR;
                end
            end else if (mon_in_txn) begin
                mon_in_txn = 0;
                if (sb_q.size() == 0) begin
                    check("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("ready_low_cycles", 32'(mon_lo), 32'(2 * W + 3));
                    check("oe_low_cycles", 32'(mon_oe), e.is_wr ? 32'd0 : 32'(2 * (W + 1)));
                    check("we_low_cycles", 32'(mon_we), e.is_wr ? 32'(2 * ((W == 0) ? 1 : W)) : 32'd0);
                    check("sram_addr_low", {14'h0, mon_first}, {14'h0, e.waddr, 1'b0});
                    check("sram_addr_high", {14'h0, mon_last}, {14'h0, e.waddr, 1'b1});
                    check("read_data", read_data, e.rdata);
                    if (e.is_wr) begin
                        check("sram_low_half", {16'h0, sram[{e.waddr, 1'b0}]}, {16'h0, e.data[15:0]});
                        check("sram_high_half", {16'h0, sram[{e.waddr, 1'b1}]}, {16'h0, e.data[31:16]});
                    end
                end
            end
        end
    end

    initial begin
        int          n;
        int          kind;
        logic [31:0] a;
        logic [17:0] addrs0[$];

        for (int i = 0; i < 131072; i++) model_word[i] = 32'h0;
        model_last_rd = 32'h0;
        rst = 0; wr_en = 0; rd_en = 0; address = 0; write_data = 0;
        rd_en0 = 0; address0 = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_read_data", read_data, 32'h0);
        check("rst_sram_addr", {14'h0, SRAM_ADDR}, 32'h0);
        check("rst_we_n", {31'h0, SRAM_WE_N}, 32'd1);
        check("rst_oe_n", {31'h0, SRAM_OE_N}, 32'd1);
        check("rst_dq_drive", {31'h0, u_dut.w_dq_oe}, 32'd0);
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        check("post_rst_ready", {31'h0, ready}, 32'd1);

        // Directed cases
        do_txn(1, 0, 32'd1024, 32'hDEADBEEF, 0);
        do_txn(0, 1, 32'd1024, 32'h0, 0);
        do_txn(1, 1, 32'd1028, 32'h12345678, 0);
        do_txn(1, 0, 32'd0, 32'h0000AAAA, 0);
        do_txn(0, 1, 32'd0, 32'h0, 0);

        // Randomized traffic
        repeat (40) begin
            kind = $urandom_range(2);
            if ($urandom_range(9) == 0) a = $urandom;
            else a = OFF + 4 * $urandom_range(15) + $urandom_range(3);
            do_txn(kind != 1, kind != 0, a, $urandom, $urandom_range(1) == 1);
        end

        @(negedge clk);
        check("queue_drained", 32'(sb_q.size()), 32'd0);

        // Reset in the HIGH phase of a write
        $display("txn RESET-IN-WRITE addr=0x%08h", OFF + 400);
        @(posedge clk); #1;
        wr_en = 1; address = OFF + 400; write_data = 32'hCAFEF00D;
        repeat (6) @(negedge clk);
        check("pre_rst_we_n", {31'h0, SRAM_WE_N}, 32'd0);
        check("pre_rst_addr", {14'h0, SRAM_ADDR}, 32'd201);
        #2 rst = 0; wr_en = 0;
        #1;
        check("mid_rst_we_n", {31'h0, SRAM_WE_N}, 32'd1);
        check("mid_rst_dq_drive", {31'h0, u_dut.w_dq_oe}, 32'd0);
        check("mid_rst_ready", {31'h0, ready}, 32'd1);
        check("mid_rst_addr", {14'h0, SRAM_ADDR}, 32'h0);
        check("mid_rst_read_data", read_data, 32'h0);
        model_last_rd = 32'h0;
        @(negedge clk);
        @(posedge clk); #1 rst = 1;
        do_txn(0, 1, 32'd1024, 32'h0, 0);

        // Zero-wait-state load at 1032
        $display("txn RD(W=0) addr=0x%08h", 32'd1032);
        @(posedge clk); #1;
        rd_en0 = 1; address0 = 32'd1032;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (!SRAM_OE_N0) addrs0.push_back(SRAM_ADDR0);
            if (ready0) break;
        end
        check("w0_cycles", 32'(n), 32'd4);
        check("w0_addr_count", 32'(addrs0.size()), 32'd2);
        if (addrs0.size() == 2) begin
            check("w0_addr_low", {14'h0, addrs0[0]}, 32'd4);
            check("w0_addr_high", {14'h0, addrs0[1]}, 32'd5);
        end
        check("w0_read_data", read_data0, {16'hA005, 16'hA004});
        @(posedge clk); #1 rd_en0 = 0;

        repeat (2) @(negedge clk);
        check("final_queue_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
